// File: rtl/riscv_under_top.sv
`default_nettype none
// ============================================================================
// Module   : riscv_under_top
// Brief    : Single-cycle RV32I subset core (add/sub/slt/or/and, addi/slti/
//            ori/andi, lw, sw) with a 64-word fixed program ROM, a 64-word
//            data memory and a 7-segment view of one register.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_under_top (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  SW,
  output logic [6:0]  HEX0,
  output logic [31:0] PC,
  output logic [31:0] INST_DATA,
  output logic [31:0] REGISTER_READ_DATA1,
  output logic [31:0] REGISTER_READ_DATA2,
  output logic [31:0] IMM_EXTR,
  output logic [31:0] ALU_RES,
  output logic [31:0] DATA_READ_DATA,
  output logic        REG_WRITE,
  output logic        IMM_SRC,
  output logic        MEM_WRITE,
  output logic [6:0]  OPECODE,
  output logic [4:0]  REGISTER_ADDRESS1,
  output logic [4:0]  REGISTER_ADDRESS2,
  output logic [4:0]  REGISTER_ADDRESS3
);

  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_LW    = 7'b0000011;
  localparam logic [6:0]  OP_SW    = 7'b0100011;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] regs [0:31];
  logic [31:0] dmem [0:63];
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  logic [31:0] alu_res;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [3:0]  hex_nibble;
  logic [6:0]  seg;
  logic        reg_write;
  logic        mem_write;
  logic        imm_src;

  // Instruction fields
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  // Program ROM, word-indexed; anything beyond the program is a nop
  always_comb begin
    case (pc[7:2])
      6'd0:    inst = 32'h00500093;  // addi x1,x0,5
      6'd1:    inst = 32'h00300113;  // addi x2,x0,3
      6'd2:    inst = 32'h002081B3;  // add  x3,x1,x2
      6'd3:    inst = 32'h00302423;  // sw   x3,8(x0)
      6'd4:    inst = 32'h00802203;  // lw   x4,8(x0)
      6'd5:    inst = 32'h401202B3;  // sub  x5,x4,x1
      default: inst = NOP_INST;
    endcase
  end

  // Register file read ports; x0 is hardwired to zero
  assign rd1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  // Only stores use the split S-type immediate
  assign imm_src = (opcode == OP_SW);
  assign imm     = imm_src ? {{20{inst[31]}}, inst[31:25], inst[11:7]}
                           : {{20{inst[31]}}, inst[31:20]};

  // Decode and ALU; unsupported encodings leave result and strobes at zero
  always_comb begin
    alu_res   = 32'd0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: alu_res = rd1 + rd2;
          10'b0100000_000: alu_res = rd1 - rd2;
          10'b0000000_010: alu_res = {31'd0, $signed(rd1) < $signed(rd2)};
          10'b0000000_110: alu_res = rd1 | rd2;
          10'b0000000_111: alu_res = rd1 & rd2;
          default:         reg_write = 1'b0;
        endcase
      end
      OP_I: begin
        reg_write = 1'b1;
        case (funct3)
          3'b000:  alu_res = rd1 + imm;
          3'b010:  alu_res = {31'd0, $signed(rd1) < $signed(imm)};
          3'b110:  alu_res = rd1 | imm;
          3'b111:  alu_res = rd1 & imm;
          default: reg_write = 1'b0;
        endcase
      end
      OP_LW: begin
        if (funct3 == 3'b010) begin
          alu_res   = rd1 + imm;
          reg_write = 1'b1;
        end
      end
      OP_SW: begin
        if (funct3 == 3'b010) begin
          alu_res   = rd1 + imm;
          mem_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Data memory read: word address from ALU_RES[7:2], higher bits alias
  assign mem_rdata = dmem[alu_res[7:2]];
  assign wb_data   = (opcode == OP_LW) ? mem_rdata : alu_res;

  // PC advance and register write-back; reset clears PC and registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= pc + 32'd4;
      if (reg_write && (rd != 5'd0)) regs[rd] <= wb_data;
    end
  end

  // Store port; memory contents survive reset
  always_ff @(posedge CLK) begin
    if (!RST && mem_write) dmem[alu_res[7:2]] <= rd2;
  end

  // 7-segment code for the low nibble of the selected register
  assign hex_nibble = (SW == 4'd0) ? 4'd0 : regs[{1'b0, SW}][3:0];

  // Active-low segment lookup, bit order {g,f,e,d,c,b,a}
  always_comb begin
    case (hex_nibble)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
  end

  assign HEX0                = seg;
  assign PC                  = pc;
  assign INST_DATA           = inst;
  assign REGISTER_READ_DATA1 = rd1;
  assign REGISTER_READ_DATA2 = rd2;
  assign IMM_EXTR            = imm;
  assign ALU_RES             = alu_res;
  assign DATA_READ_DATA      = mem_rdata;
  assign REG_WRITE           = reg_write;
  assign IMM_SRC             = imm_src;
  assign MEM_WRITE           = mem_write;
  assign OPECODE             = opcode;
  assign REGISTER_ADDRESS1   = rs1;
  assign REGISTER_ADDRESS2   = rs2;
  assign REGISTER_ADDRESS3   = rd;

endmodule
`default_nettype wire

// File: tb/tb_riscv_under_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_under_top
// Brief    : Scoreboard bench for riscv_under_top. An instruction-level model
//            predicts every output each cycle; a monitor compares at negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_under_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sw  = 4'd0;
  logic [6:0]  hex0;
  logic [31:0] pc, inst, rd1, rd2, imm, alu, dread;
  logic        reg_write, imm_src, mem_write;
  logic [6:0]  opcode;
  logic [4:0]  ra1, ra2, ra3;

  riscv_under_top dut (
    .CLK(clk), .RST(rst), .SW(sw), .HEX0(hex0), .PC(pc), .INST_DATA(inst),
    .REGISTER_READ_DATA1(rd1), .REGISTER_READ_DATA2(rd2), .IMM_EXTR(imm),
    .ALU_RES(alu), .DATA_READ_DATA(dread), .REG_WRITE(reg_write),
    .IMM_SRC(imm_src), .MEM_WRITE(mem_write), .OPECODE(opcode),
    .REGISTER_ADDRESS1(ra1), .REGISTER_ADDRESS2(ra2), .REGISTER_ADDRESS3(ra3)
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] pc, inst, rd1, rd2, imm, alu, dread;
    logic        dknown, rw, isrc, mw;
    logic [6:0]  hex;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cycle  = 0;

  // Architectural model state
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [64];
  bit          m_known[64];
  bit          m_valid = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [31:0] program_word(input logic [31:0] addr);
    case (addr[7:2])
      6'd0: return 32'h00500093;
      6'd1: return 32'h00300113;
      6'd2: return 32'h002081B3;
      6'd3: return 32'h00302423;
      6'd4: return 32'h00802203;
      6'd5: return 32'h401202B3;
      default: return 32'h00000013;
    endcase
  endfunction

  // Predict the combinational view of the current architectural state
  task automatic predict(output exp_t e);
    logic [31:0] w, a, b, immi, imms;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    w    = program_word(m_pc);
    op   = w[6:0];
    f3   = w[14:12];
    f7   = w[31:25];
    a    = m_regs[w[19:15]];
    b    = m_regs[w[24:20]];
    immi = {{20{w[31]}}, w[31:20]};
    imms = {{20{w[31]}}, w[31:25], w[11:7]};
    e.cyc  = cycle;
    e.pc   = m_pc;
    e.inst = w;
    e.rd1  = a;
    e.rd2  = b;
    e.isrc = (op == 7'h23);
    e.imm  = e.isrc ? imms : immi;
    e.alu  = 0; e.rw = 0; e.mw = 0;
    if (op == 7'h33) begin
      e.rw = 1;
      if      (f3 == 0 && f7 == 0)     e.alu = a + b;
      else if (f3 == 0 && f7 == 7'h20) e.alu = a - b;
      else if (f3 == 2 && f7 == 0)     e.alu = ($signed(a) < $signed(b)) ? 1 : 0;
      else if (f3 == 6 && f7 == 0)     e.alu = a | b;
      else if (f3 == 7 && f7 == 0)     e.alu = a & b;
      else                             e.rw  = 0;
    end else if (op == 7'h13) begin
      e.rw = 1;
      if      (f3 == 0) e.alu = a + immi;
      else if (f3 == 2) e.alu = ($signed(a) < $signed(immi)) ? 1 : 0;
      else if (f3 == 6) e.alu = a | immi;
      else if (f3 == 7) e.alu = a & immi;
      else              e.rw  = 0;
    end else if (op == 7'h03 && f3 == 2) begin
      e.alu = a + immi; e.rw = 1;
    end else if (op == 7'h23 && f3 == 2) begin
      e.alu = a + imms; e.mw = 1;
    end
    e.dknown = m_known[e.alu[7:2]];
    e.dread  = m_mem[e.alu[7:2]];
    e.hex    = seg_tab[m_regs[{1'b0, sw}][3:0]];
  endtask

  // One clock: drive inputs, queue the expectation, then advance the model
  task automatic step(input logic r, input logic [3:0] s);
    exp_t e;
    rst = r;
    sw  = s;
    if (m_valid) begin
      predict(e);
      q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_valid = 1;
    end else if (m_valid) begin
      predict(e);
      if (e.rw && e.inst[11:7] != 0)
        m_regs[e.inst[11:7]] = (e.inst[6:0] == 7'h03) ? e.dread : e.alu;
      if (e.mw) begin
        m_mem[e.alu[7:2]]   = e.rd2;
        m_known[e.alu[7:2]] = 1;
      end
      m_pc = m_pc + 4;
    end
    cycle++;
    #1;
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  // Monitor: every cycle presents a full set of outputs; compare at negedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",        e.cyc, pc,   e.pc);
        chk("inst",      e.cyc, inst, e.inst);
        chk("opcode",    e.cyc, {25'd0, opcode}, {25'd0, e.inst[6:0]});
        chk("ra1",       e.cyc, {27'd0, ra1}, {27'd0, e.inst[19:15]});
        chk("ra2",       e.cyc, {27'd0, ra2}, {27'd0, e.inst[24:20]});
        chk("ra3",       e.cyc, {27'd0, ra3}, {27'd0, e.inst[11:7]});
        chk("rd1",       e.cyc, rd1,  e.rd1);
        chk("rd2",       e.cyc, rd2,  e.rd2);
        chk("imm",       e.cyc, imm,  e.imm);
        chk("alu",       e.cyc, alu,  e.alu);
        chk("reg_write", e.cyc, {31'd0, reg_write}, {31'd0, e.rw});
        chk("imm_src",   e.cyc, {31'd0, imm_src},   {31'd0, e.isrc});
        chk("mem_write", e.cyc, {31'd0, mem_write}, {31'd0, e.mw});
        chk("hex0",      e.cyc, {25'd0, hex0}, {25'd0, e.hex});
        if (e.dknown) chk("dread", e.cyc, dread, e.dread);
      end
    end
  end

  // Stimulus: directed program walk, reset restart, then randomized run
  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    for (int i = 0; i < 64; i++) begin m_mem[i] = 0; m_known[i] = 0; end
    m_pc = 0;

    step(1, 4'd0);
    foreach (seg_tab[i]) if (i < 7) step(0, 4'(i));
    step(0, 4'd5);
    step(0, 4'd1);
    step(0, 4'd0);
    step(1, 4'd3);
    for (int i = 0; i < 8; i++) step(0, 4'd3);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 29) == 0), 4'($urandom_range(0, 15)));

    step(0, 4'd0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", cycle, q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL timeout cycle=%0d actual=running required=finished", cycle);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/riscv_under_top.md
RISCV_UNDER_TOP -- requirements
Module: riscv_under_top

Interface
REQ-001 SHALL: CLK  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: RST  in  1  reset, synchronous, active-high.
REQ-003 SHALL: SW  in  4  register-file index (x0..x15) shown on HEX0.
REQ-004 SHALL: HEX0  out  7  7-segment {g,f,e,d,c,b,a}, active-low.
REQ-005 SHALL: PC  out  32  current program counter.
REQ-006 SHALL: INST_DATA  out  32  instruction at PC.
REQ-007 SHALL: REGISTER_READ_DATA1/2  out  32 each  register file rs1/rs2 read data.
REQ-008 SHALL: IMM_EXTR  out  32  sign-extended immediate.
REQ-009 SHALL: ALU_RES  out  32  ALU result.
REQ-010 SHALL: DATA_READ_DATA  out  32  data memory word at ALU_RES.
REQ-011 SHALL: REG_WRITE, IMM_SRC, MEM_WRITE  out  1 each  decoded controls.
REQ-012 SHALL: OPECODE  out  7  INST_DATA[6:0].
REQ-013 SHALL: REGISTER_ADDRESS1/2/3  out  5 each  INST_DATA[19:15] / [24:20] / [11:7].
REQ-014 SHALL: one clock; reset is synchronous and active-high (CLK, RST).

Function
REQ-015 SHALL: single-cycle RV32I subset; every non-PC output combinational from current PC and state.
REQ-016 SHALL: instruction ROM 64 words, indexed by PC[7:2], content: 0x00 0x00500093 (addi x1,x0,5); 0x04 0x00300113 (addi x2,x0,3); 0x08 0x002081B3 (add x3,x1,x2); 0x0C 0x00302423 (sw x3,8(x0)); 0x10 0x00802203 (lw x4,8(x0)); 0x14 0x401202B3 (sub x5,x4,x1); all other words 0x00000013 (nop).
REQ-017 SHALL: opcodes: 0110011 R-type, 0010011 I-arith, 0000011 lw (funct3 010), 0100011 sw (funct3 010); anything else is a nop: REG_WRITE=0, MEM_WRITE=0.
REQ-018 SHALL: IMM_SRC=0 I-imm {sext INST[31:20]}; IMM_SRC=1 (sw only) S-imm {sext INST[31:25],INST[11:7]}.
REQ-019 SHALL: R-type funct3/funct7: 000/0000000 add, 000/0100000 sub, 010 slt (signed), 110 or, 111 and; I-arith 000 addi, 010 slti, 110 ori, 111 andi (funct7 ignored).
REQ-020 SHALL: unsupported funct3/funct7 combination -> ALU_RES=0, REG_WRITE=0.
REQ-021 SHALL: lw/sw ALU_RES = rs1+imm, 32-bit wrap-around; data memory 64 words indexed by ALU_RES[7:2], low two bits ignored, upper bits alias.
REQ-022 SHALL: REG_WRITE=1 for supported R/I-arith/lw; write-back = ALU_RES (arith) or DATA_READ_DATA (lw) into rd at rising edge.
REQ-023 SHALL: x0 reads 0 always; writes to x0 discarded; register file 32x32, two async read ports.
REQ-024 SHALL: MEM_WRITE=1 for sw only; rs2 data written to data memory at rising edge; data memory 0 at power-up.
REQ-025 SHALL: PC <= PC+4 every non-reset rising edge (no branches), 32-bit wrap.
REQ-026 SHALL: HEX0 = active-low segment code of register x[SW] bits [3:0]: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex of {g..a}).

Reset
REQ-027 SHALL: RST=1 at rising edge -> PC=0, x1..x31=0, no register or memory write that cycle; data memory unaffected.
REQ-028 SHALL: first rising edge with RST=0 executes the instruction at PC 0x00.
REQ-029 SHALL: reset asserted mid-program restarts at PC 0 next edge, regardless of instruction in flight.

Verification
REQ-030 SHALL: RST=1 one edge, SW=0 -> PC=0, INST_DATA=0x00500093, OPECODE=0x13, IMM_EXTR=5, ALU_RES=5, REG_WRITE=1, IMM_SRC=0, HEX0=0x40.
REQ-031 SHALL: release RST, 3 edges -> PC=0x0C, x3=8, MEM_WRITE=1, IMM_SRC=1, IMM_EXTR=8, ALU_RES=8, REGISTER_READ_DATA2=8.
REQ-032 SHALL: 4 edges -> PC=0x10, DATA_READ_DATA=8, REG_WRITE=1, REGISTER_ADDRESS3=4.
REQ-033 SHALL: 6 edges -> x5=3; SW=5 -> HEX0=0x30; SW=1 -> 0x12; SW=0 -> 0x40.
REQ-034 SHALL: after 6 edges, RST=1 one edge -> PC=0, SW=3 -> HEX0=0x40 (x3 cleared); DATA_READ_DATA at ALU_RES=8 still 8 once PC reaches 0x10 again.
REQ-035 SHALL: nop region (PC >= 0x18) -> INST_DATA=0x00000013, REG_WRITE=1 targeting x0, x0 remains 0, MEM_WRITE=0.
